sr_input_conditioner: RTL and testbench
=======================================

SR_INPUT_CONDITIONER -- requirements
Module: sr_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL give the consecutive stable cycles (legal 1..255) needed to accept an input change.
REQ-002 Parameter PULSE_MODE, default 1, SHALL select 1 = single-cycle command pulses, 0 = level-following commands.
REQ-003 Parameter HOLDOFF_CYCLES, default 2, SHALL give lockout cycles (legal 0..255) after each pulse in PULSE_MODE=1.
REQ-004 Port clock, input, 1, SHALL be the single rising-edge clock.
REQ-005 Port reset, input, 1, SHALL be the asynchronous, active-high reset.
REQ-006 Port set_in, input, 1, SHALL be the raw, asynchronous set request (button/level).
REQ-007 Port clr_in, input, 1, SHALL be the raw, asynchronous clear request.
REQ-008 Port s, output, 1, SHALL be the registered set command driving the downstream SR flip-flop s input.
REQ-009 Port r, output, 1, SHALL be the registered reset command driving the downstream SR flip-flop r input.
REQ-010 Port conflict, output, 1, SHALL flag simultaneous set and clear requests.

Function
REQ-011 Each raw input SHALL pass a two-flop synchronizer; no logic other than the second flop SHALL consume the first flop.
REQ-012 Each channel SHALL hold a debounced state deb and a counter wide enough for DEBOUNCE_CYCLES.
REQ-013 Counter SHALL increment on each edge where sync output differs from deb, and clear on any edge where they match.
REQ-014 deb SHALL toggle, and its counter clear, on the edge where the difference has been sampled DEBOUNCE_CYCLES consecutive times.
REQ-015 Latency: a clean raw change SHALL appear on s/r at rising edge DEBOUNCE_CYCLES+3 after setup (edge 7 for default).
REQ-016 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change in deb, s, r or conflict.
REQ-017 PULSE_MODE=1: a 0->1 change of set deb SHALL produce s=1 for exactly one cycle; likewise clear deb -> r; 1->0 changes produce nothing.
REQ-018 PULSE_MODE=1 FSM states: IDLE (accept edges), LOCK (count HOLDOFF_CYCLES, then IDLE).
REQ-019 IDLE -> LOCK SHALL occur on the edge that issues any s or r pulse; HOLDOFF_CYCLES=0 SHALL stay in IDLE.
REQ-020 Rising deb edges during LOCK SHALL be discarded, not queued.
REQ-021 PULSE_MODE=1: set and clear deb rising on the same edge in IDLE SHALL give s=0, r=0, conflict=1 for one cycle, and enter LOCK.
REQ-022 PULSE_MODE=0: s SHALL equal set deb and r SHALL equal clear deb, registered one cycle later.
REQ-023 PULSE_MODE=0: while both deb are 1, s=0, r=0 and conflict=1, held until either deb falls.
REQ-024 s and r SHALL never be 1 in the same cycle, in any mode or state.
REQ-025 All outputs SHALL be driven directly from flops.

Reset
REQ-026 reset=1 SHALL immediately, without a clock, force s=0, r=0, conflict=0, synchronizers=0, deb=0, counters=0, FSM=IDLE.
REQ-027 Reset asserted mid-debounce or mid-LOCK SHALL abandon the operation; no pulse SHALL follow deassertion unless a fresh full debounce completes.
REQ-028 After deassertion, an input already held at 1 SHALL be treated as a new 0->1 change (pulse after DEBOUNCE_CYCLES+3 edges).

Verification
REQ-029 Defaults; set_in 0->1 held 20 cycles -> s=1 only at edge 7, r=0, conflict=0 throughout.
REQ-030 Defaults; set_in high for 3 cycles then low -> s, r, conflict stay 0.
REQ-031 Defaults; set_in and clr_in rise together -> conflict=1 at edge 7 for one cycle, s=r=0 throughout.
REQ-032 Defaults; clr_in pulse accepted, set_in deb rises inside 2-cycle LOCK -> r pulse only, set request dropped, no s pulse.
REQ-033 PULSE_MODE=0; set_in high, then clr_in high -> s=1, then s=0,r=0,conflict=1; release set_in -> r=1, conflict=0.
REQ-034 Async reset asserted between clock edges mid-debounce -> outputs 0 at once; set_in still high -> s pulse DEBOUNCE_CYCLES+3 edges after release.

Source files
------------

// File: rtl/sr_input_conditioner.sv
// Conditions raw set/clear requests for a downstream SR flip-flop: two-flop sync,
// debounce, then either one-shot pulses with holdoff lockout or level-following commands.
module sr_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_MODE      = 1,
    parameter int unsigned HOLDOFF_CYCLES  = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic set_in,
    input  logic clr_in,
    output logic s,
    output logic r,
    output logic conflict,
    output logic dbg_state
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 2);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Channel index 0 carries the set request, index 1 the clear request.
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         deb_q, deb_d;
    logic [1:0]         deb_prev_q;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         rise;

    state_t             state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               s_q, s_d;
    logic               r_q, r_d;
    logic               conflict_q, conflict_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // deb_prev lags deb by one edge, so a rising edge is visible for exactly one cycle.
    assign rise = deb_q & ~deb_prev_q;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        s_d        = 1'b0;
        r_d        = 1'b0;
        conflict_d = 1'b0;
        if (PULSE_MODE != 0) begin
            case (state_q)
                IDLE: begin
                    if (rise != 2'b00) begin
                        s_d        = (rise == 2'b01);
                        r_d        = (rise == 2'b10);
                        conflict_d = (rise == 2'b11);
                        if (HOLDOFF_CYCLES != 0) begin
                            state_d = LOCK;
                            hold_d  = '0;
                        end
                    end
                end
                LOCK: begin
                    // Rising edges seen here are dropped on purpose, never queued.
                    if (hold_q == HOLD_LAST) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase
        end else begin
            s_d        = deb_q[0] & ~deb_q[1];
            r_d        = deb_q[1] & ~deb_q[0];
            conflict_d = deb_q[0] & deb_q[1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q      <= '0;
            state_q    <= IDLE;
            hold_q     <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= {clr_in, set_in};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            hold_q     <= hold_d;
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign s         = s_q;
    assign r         = r_q;
    assign conflict  = conflict_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Bench for sr_input_conditioner: a pulse-mode instance with defaults and a level-mode
// instance, driven from per-cycle vector tables plus hand-written reset sequences.
module tb_sr_input_conditioner;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic set_in = 1'b0, clr_in = 1'b0;
    logic lset = 1'b0, lclr = 1'b0;
    logic s, r, conflict, dbg_state;
    logic ls, lr, lconflict, ldbg_state;

    always #5 clock = ~clock;

    sr_input_conditioner dut (
        .clock(clock), .reset(reset), .set_in(set_in), .clr_in(clr_in),
        .s(s), .r(r), .conflict(conflict), .dbg_state(dbg_state)
    );

    sr_input_conditioner #(.PULSE_MODE(0)) dut_lvl (
        .clock(clock), .reset(reset), .set_in(lset), .clr_in(lclr),
        .s(ls), .r(lr), .conflict(lconflict), .dbg_state(ldbg_state)
    );

    // One record per clock: inputs held before edge k, outputs expected just after it.
    typedef struct {
        bit    lvl;
        string tag;
        logic  set_in;
        logic  clr_in;
        logic  s;
        logic  r;
        logic  conflict;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] exp_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;

    task automatic add(input bit lvl, input string tag, input logic si, input logic ci,
                       input logic es, input logic er, input logic ec);
        vec_t v;
        v.lvl = lvl; v.tag = tag; v.set_in = si; v.clr_in = ci;
        v.s = es; v.r = er; v.conflict = ec;
        vecs.push_back(v);
    endtask

    task automatic add_idle(input bit lvl, input int n);
        for (int k = 0; k < n; k++) add(lvl, "idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got s/r/conflict=%b, expected %b", name, got, exp);
        end
    endtask

    task automatic apply_table();
        logic [2:0] got;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            set_in = vecs[i].lvl ? 1'b0 : vecs[i].set_in;
            clr_in = vecs[i].lvl ? 1'b0 : vecs[i].clr_in;
            lset   = vecs[i].lvl ? vecs[i].set_in : 1'b0;
            lclr   = vecs[i].lvl ? vecs[i].clr_in : 1'b0;
            exp_q.push_back({vecs[i].s, vecs[i].r, vecs[i].conflict});
            @(posedge clock);
            #1;
            got = vecs[i].lvl ? {ls, lr, lconflict} : {s, r, conflict};
            check($sformatf("%s[%0d]", vecs[i].tag, i), got, exp_q.pop_front());
            check($sformatf("s_r_exclusive[%0d]", i), {2'b00, got[2] & got[1]}, 3'b000);
        end
    endtask

    task automatic reset_sequence();
        @(negedge clock);
        set_in = 1'b1; clr_in = 1'b0; lset = 1'b0; lclr = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clock); #1;
            check($sformatf("rst_pre_pulse[%0d]", k), {s, r, conflict}, {k == 7, 2'b00});
        end
        // Assert between edges while s is high and the FSM has just entered LOCK.
        #2 reset = 1'b1;
        #1;
        check("rst_async_outputs", {s, r, conflict}, 3'b000);
        check("rst_async_fsm", {2'b00, dbg_state}, 3'b000);
        @(posedge clock); #1;
        check("rst_held", {s, r, conflict}, 3'b000);
        @(negedge clock) reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock); #1;
            check($sformatf("rst_mid_debounce[%0d]", k), {s, r, conflict}, 3'b000);
        end
        #2 reset = 1'b1;
        #1;
        check("rst_mid_debounce_async", {s, r, conflict}, 3'b000);
        @(negedge clock) reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clock); #1;
            check($sformatf("rst_repulse[%0d]", k), {s, r, conflict}, {k == 7, 2'b00});
        end
        @(negedge clock) set_in = 1'b0;
        repeat (12) @(posedge clock);
    endtask

    initial begin
        // Clean set held: single s pulse at edge 7.
        for (int k = 1; k <= 20; k++) add(1'b0, "set_hold", 1'b1, 1'b0, k == 7, 1'b0, 1'b0);
        add_idle(1'b0, 12);
        // Three-cycle glitch is rejected.
        for (int k = 1; k <= 3; k++) add(1'b0, "glitch3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_idle(1'b0, 12);
        // Four-cycle input is just long enough to be accepted.
        for (int k = 1; k <= 16; k++) add(1'b0, "pulse4", k <= 4, 1'b0, k == 7, 1'b0, 1'b0);
        add_idle(1'b0, 4);
        // Clear alone gives an r pulse.
        for (int k = 1; k <= 16; k++) add(1'b0, "clr_only", 1'b0, k <= 8, 1'b0, k == 7, 1'b0);
        add_idle(1'b0, 4);
        // Simultaneous rise: one conflict cycle, no s or r.
        for (int k = 1; k <= 20; k++) add(1'b0, "both", 1'b1, 1'b1, 1'b0, 1'b0, k == 7);
        add_idle(1'b0, 12);
        // Set deb rises during LOCK after the r pulse and is dropped.
        for (int k = 1; k <= 20; k++) add(1'b0, "lock_drop", k >= 3, 1'b1, 1'b0, k == 7, 1'b0);
        add_idle(1'b0, 12);
        // Set deb rises on the first IDLE cycle after LOCK and is honoured.
        for (int k = 1; k <= 20; k++) add(1'b0, "lock_end", k >= 4, 1'b1, k == 10, k == 7, 1'b0);
        add_idle(1'b0, 12);
        // Level mode: set, then clear on top (conflict), then release set (r follows).
        for (int k = 1; k <= 40; k++)
            add(1'b1, "level", k <= 20, (k >= 11) && (k <= 30),
                (k >= 7) && (k <= 16), (k >= 27) && (k <= 36), (k >= 17) && (k <= 26));
        add_idle(1'b1, 6);

        #1;
        check("reset_pulse_dut", {s, r, conflict}, 3'b000);
        check("reset_level_dut", {ls, lr, lconflict}, 3'b000);
        check("reset_fsm_idle", {2'b00, dbg_state}, 3'b000);
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;

        apply_table();
        reset_sequence();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
